// File: rtl/seconds_counter_display_pkg.sv
// Shared constants and types for the MM:SS seconds counter and its 7-segment display.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seconds_counter_display_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Enumerator value doubles as the anode index (0 = rightmost digit).
  typedef enum logic [1:0] {
    DigSecOnes = 2'd0,
    DigSecTens = 2'd1,
    DigMinOnes = 2'd2,
    DigMinTens = 2'd3
  } digit_sel_e;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  function automatic logic [3:0] anode_onehot_n(digit_sel_e sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/seconds_counter_display_if.sv
// Signal bundle between the seconds counter/display and its environment.
// master drives the divided clock and controls; slave is the counter/display block.
interface seconds_counter_display_if;
  import seconds_counter_display_pkg::*;

  logic       divided_clk_in;
  logic       count_en_in;
  logic       clear_in;
  logic       sec_tick_out;
  logic       wrap_out;
  bcd_time_t  bcd_out;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  logic       dp_out;

  modport master (
    output divided_clk_in, count_en_in, clear_in,
    input  sec_tick_out, wrap_out, bcd_out, seg_out, an_out, dp_out
  );

  modport slave (
    input  divided_clk_in, count_en_in, clear_in,
    output sec_tick_out, wrap_out, bcd_out, seg_out, an_out, dp_out
  );

endinterface

// File: rtl/seconds_counter_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes blank the digit.
module seconds_counter_display_bcd_to_7seg
  import seconds_counter_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seconds_counter_display.sv
// Samples the 1 Hz divided clock, turns rising edges into second ticks, keeps an MM:SS BCD count
// and scans it onto a 4-digit multiplexed active-low 7-segment display.
module seconds_counter_display
  import seconds_counter_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  seconds_counter_display_if.slave   bus
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);
  localparam logic [RefW-1:0] RefOne  = RefW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_sec_tick;
  logic                   r_wrap;
  logic                   w_tick;
  bcd_time_t              r_time;
  bcd_time_t              w_time_next;
  logic                   w_wrap_next;
  logic [RefW-1:0]        r_refresh;
  digit_sel_e             r_sel;
  logic [3:0]             w_digit;
  logic [6:0]             w_seg;
  logic [6:0]             r_seg;
  logic [3:0]             r_an;
  logic                   r_dp;

  // History resets high so an input already high at reset release is not an edge.
  assign w_tick = r_sync[SYNC_STAGES-1] & ~r_prev;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync     <= '1;
      r_prev     <= 1'b1;
      r_sec_tick <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.divided_clk_in};
      r_prev     <= r_sync[SYNC_STAGES-1];
      r_sec_tick <= w_tick;
    end
  end

  always_comb begin
    w_time_next = r_time;
    w_wrap_next = 1'b0;
    if (bus.clear_in) begin
      w_time_next = '0;
    end else if (r_sec_tick && bus.count_en_in) begin
      if (r_time.sec_ones != 4'd9) begin
        w_time_next.sec_ones = r_time.sec_ones + 4'd1;
      end else begin
        w_time_next.sec_ones = 4'd0;
        if (r_time.sec_tens != 4'd5) begin
          w_time_next.sec_tens = r_time.sec_tens + 4'd1;
        end else begin
          w_time_next.sec_tens = 4'd0;
          if (r_time.min_ones != 4'd9) begin
            w_time_next.min_ones = r_time.min_ones + 4'd1;
          end else begin
            w_time_next.min_ones = 4'd0;
            if (r_time.min_tens != 4'd5) begin
              w_time_next.min_tens = r_time.min_tens + 4'd1;
            end else begin
              w_time_next.min_tens = 4'd0;
              w_wrap_next          = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_time <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_time <= w_time_next;
      r_wrap <= w_wrap_next;
    end
  end

  always_comb begin
    w_digit = 4'd0;
    unique case (r_sel)
      DigSecOnes: w_digit = r_time.sec_ones;
      DigSecTens: w_digit = r_time.sec_tens;
      DigMinOnes: w_digit = r_time.min_ones;
      DigMinTens: w_digit = r_time.min_tens;
      default:    w_digit = 4'd0;
    endcase
  end

  seconds_counter_display_bcd_to_7seg u_bcd_to_7seg (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_refresh <= '0;
      r_sel     <= DigSecOnes;
      r_seg     <= SEG_BLANK;
      r_an      <= 4'hF;
      r_dp      <= 1'b1;
    end else begin
      if (r_refresh == RefLast) begin
        r_refresh <= '0;
        r_sel     <= digit_sel_e'(r_sel + 2'd1);
      end else begin
        r_refresh <= r_refresh + RefOne;
      end
      r_seg <= w_seg;
      r_an  <= anode_onehot_n(r_sel);
      r_dp  <= (r_sel != DigMinOnes);
    end
  end

  assign bus.sec_tick_out = r_sec_tick;
  assign bus.wrap_out     = r_wrap;
  assign bus.bcd_out      = r_time;
  assign bus.seg_out      = r_seg;
  assign bus.an_out       = r_an;
  assign bus.dp_out       = r_dp;

endmodule
